// File: rtl/pipelined_adder_nbit_pkg.sv
// Shared constants and types for the pipelined WIDTH-bit add/subtract unit.
package adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic cout;
    logic ovf;
  } flags_t;

  function automatic int num_stages(input int width, input int chunk);
    return (chunk > 0) ? (width / chunk) : 0;
  endfunction

endpackage

// File: rtl/pipelined_adder_nbit_if.sv
// Operand/result handshake bundle; the adder is the slave, source/consumer the master.
interface pipelined_adder_nbit_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_op, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_op, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/pipelined_adder_nbit_slice.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into its top bit.
module adder_slice #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);
  logic [CHUNK:0] c;

  always_comb begin
    sum  = '0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = c[CHUNK];
  assign c_msb = c[CHUNK-1];
endmodule

// File: rtl/pipelined_adder_nbit.sv
// WIDTH-bit add/subtract, carry chain cut into CHUNK-bit slices with one slice per pipeline stage.
module pipelined_adder_nbit
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  pipelined_adder_nbit_if.slave bus
);
  localparam int NUM_STAGES = num_stages(WIDTH, CHUNK);

  if (CHUNK < 1 || NUM_STAGES < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("pipelined_adder_nbit: WIDTH must be a positive multiple of CHUNK");
  end

  logic                  adv;
  logic                  rdy_q;
  logic [NUM_STAGES-1:0] vld_q;
  logic [WIDTH-1:0]      a_q   [NUM_STAGES];
  logic [WIDTH-1:0]      b_q   [NUM_STAGES];
  logic [WIDTH-1:0]      sum_q [NUM_STAGES];
  logic                  c_q   [NUM_STAGES];
  logic [WIDTH-1:0]      out_sum_q;
  flags_t                flags_q;

  logic [WIDTH-1:0]      a_src   [NUM_STAGES];
  logic [WIDTH-1:0]      b_src   [NUM_STAGES];
  logic [WIDTH-1:0]      sum_src [NUM_STAGES];
  logic [WIDTH-1:0]      sum_d   [NUM_STAGES];
  logic [NUM_STAGES-1:0] c_src;
  logic [WIDTH-1:0]      slice_a;
  logic [WIDTH-1:0]      slice_b;
  logic [WIDTH-1:0]      slice_sum;
  logic [NUM_STAGES-1:0] slice_cout;
  logic                  slice_cmsb [NUM_STAGES];

  // Whole pipeline moves together; a stalled output freezes every stage, bubbles included.
  assign adv          = !vld_q[NUM_STAGES-1] || bus.out_ready;
  assign bus.in_ready = adv && rdy_q;

  // Stage k operands: stage 0 from the port (B inverted for SUB), later stages from skew regs.
  always_comb begin
    a_src[0]   = bus.in_a;
    b_src[0]   = (bus.in_op == OP_SUB) ? ~bus.in_b : bus.in_b;
    sum_src[0] = '0;
    c_src      = '0;
    c_src[0]   = (bus.in_op == OP_SUB) ? 1'b1 : bus.in_cin;
    for (int k = 1; k < NUM_STAGES; k++) begin
      a_src[k]   = a_q[k-1];
      b_src[k]   = b_q[k-1];
      sum_src[k] = sum_q[k-1];
      c_src[k]   = c_q[k-1];
    end
    slice_a = '0;
    slice_b = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      slice_a[k*CHUNK +: CHUNK] = a_src[k][k*CHUNK +: CHUNK];
      slice_b[k*CHUNK +: CHUNK] = b_src[k][k*CHUNK +: CHUNK];
    end
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_slice
    adder_slice #(.CHUNK(CHUNK)) u_slice (
      .a     (slice_a[k*CHUNK +: CHUNK]),
      .b     (slice_b[k*CHUNK +: CHUNK]),
      .cin   (c_src[k]),
      .sum   (slice_sum[k*CHUNK +: CHUNK]),
      .cout  (slice_cout[k]),
      .c_msb (slice_cmsb[k])
    );
  end

  always_comb begin
    for (int k = 0; k < NUM_STAGES; k++) begin
      sum_d[k]                  = sum_src[k];
      sum_d[k][k*CHUNK +: CHUNK] = slice_sum[k*CHUNK +: CHUNK];
    end
  end

  // Control and output registers: cleared asynchronously so no stale result survives reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q     <= 1'b0;
      vld_q     <= '0;
      out_sum_q <= '0;
      flags_q   <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (adv) begin
        vld_q        <= (vld_q << 1) | NUM_STAGES'(bus.in_valid && rdy_q);
        out_sum_q    <= sum_d[NUM_STAGES-1];
        flags_q.cout <= slice_cout[NUM_STAGES-1];
        flags_q.ovf  <= slice_cmsb[NUM_STAGES-1] ^ slice_cout[NUM_STAGES-1];
      end
    end
  end

  // Inter-stage data and skew registers; contents of bubble stages are don't-care.
  always_ff @(posedge clk) begin
    if (adv) begin
      for (int k = 0; k < NUM_STAGES - 1; k++) begin
        a_q[k]   <= a_src[k];
        b_q[k]   <= b_src[k];
        sum_q[k] <= sum_d[k];
        c_q[k]   <= slice_cout[k];
      end
    end
  end

  assign bus.out_valid = vld_q[NUM_STAGES-1];
  assign bus.out_sum   = out_sum_q;
  assign bus.out_cout  = flags_q.cout;
  assign bus.out_ovf   = flags_q.ovf;
endmodule

// File: tb/tb_pipelined_adder_nbit.sv
// Bench for pipelined_adder_nbit (WIDTH=16, CHUNK=4): arithmetic model, handshake monitor, directed cases.
module tb_pipelined_adder_nbit;
  import adder_pkg::*;

  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
  localparam int LAT   = 4;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } res_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_adder_nbit_if #(.WIDTH(WIDTH)) bus ();

  pipelined_adder_nbit #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   checks   = 0;
  int   failures = 0;
  int   n_out    = 0;
  res_t exp_q[$];

  // Plain integer arithmetic: unsigned result for sum/carry, signed range test for overflow.
  function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic op);
    res_t r;
    int   ua, ub, sa, sb, u, s;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (op == OP_ADD) begin
      u      = ua + ub + int'(cin);
      s      = sa + sb + int'(cin);
      r.cout = (u > 65535);
    end else begin
      u      = ua - ub;
      s      = sa - sb;
      r.cout = (ua >= ub);
    end
    r.sum = u[15:0];
    r.ovf = (s > 32767) || (s < -32768);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  initial begin : monitor
    res_t             e;
    logic             stall_prev;
    logic [WIDTH-1:0] ps;
    logic             pc, po;
    int               rel;
    stall_prev = 1'b0;
    rel        = 0;
    ps = '0; pc = 1'b0; po = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        stall_prev = 1'b0;
        rel        = 0;
      end else begin
        if (rel < 2) rel++;
        if (rel >= 2) chk("in_ready_vs_adv", bus.in_ready, !bus.out_valid || bus.out_ready);
        if (stall_prev) begin
          chk("hold_valid", bus.out_valid, 1'b1);
          chk("hold_sum", bus.out_sum, ps);
          chk("hold_cout", bus.out_cout, pc);
          chk("hold_ovf", bus.out_ovf, po);
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            fail_event("unexpected_result");
          end else begin
            e = exp_q.pop_front();
            chk("model_sum", bus.out_sum, e.sum);
            chk("model_cout", bus.out_cout, e.cout);
            chk("model_ovf", bus.out_ovf, e.ovf);
            n_out++;
          end
        end
        stall_prev = bus.out_valid && !bus.out_ready;
        ps = bus.out_sum;
        pc = bus.out_cout;
        po = bus.out_ovf;
        if (bus.in_valid && bus.in_ready)
          exp_q.push_back(model(bus.in_a, bus.in_b, bus.in_cin, bus.in_op));
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that transferred the beat.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic cin, input logic op);
    int tries;
    tries        = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    bus.in_op    = op;
    forever begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      tries++;
      if (tries > 50) begin
        fail_event("send_timeout");
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 20);
  endtask

  task automatic run_directed(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input logic cin, input logic op,
                              input logic [WIDTH-1:0] es, input logic ec, input logic eo);
    int n;
    send(a, b, cin, op);
    wait_out(n);
    chk({name, "_latency"}, n, LAT);
    chk({name, "_sum"}, bus.out_sum, es);
    chk({name, "_cout"}, bus.out_cout, ec);
    chk({name, "_ovf"}, bus.out_ovf, eo);
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "simulation time limit reached");
  end

  initial begin : main
    res_t r;
    int   n0, t;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.in_op     = OP_ADD;
    bus.out_ready = 1'b1;

    r = model(16'h0003, 16'h0004, 1'b0, OP_ADD);
    chk("pin_add_small", {r.sum, r.cout, r.ovf}, {16'h0007, 1'b0, 1'b0});
    r = model(16'hFFFF, 16'h0001, 1'b0, OP_ADD);
    chk("pin_add_wrap", {r.sum, r.cout, r.ovf}, {16'h0000, 1'b1, 1'b0});
    r = model(16'h7FFF, 16'h0001, 1'b0, OP_ADD);
    chk("pin_add_ovf", {r.sum, r.cout, r.ovf}, {16'h8000, 1'b0, 1'b1});
    r = model(16'h8000, 16'h0001, 1'b0, OP_SUB);
    chk("pin_sub_ovf", {r.sum, r.cout, r.ovf}, {16'h7FFF, 1'b1, 1'b1});
    r = model(16'h0005, 16'h0007, 1'b1, OP_SUB);
    chk("pin_sub_borrow", {r.sum, r.cout, r.ovf}, {16'hFFFE, 1'b0, 1'b0});

    #12;
    chk("reset_valid", bus.out_valid, 1'b0);
    chk("reset_sum", bus.out_sum, 16'h0000);
    chk("reset_flags", {bus.out_cout, bus.out_ovf}, 2'b00);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_release", bus.in_ready, 1'b1);

    run_directed("add_small",   16'h0003, 16'h0004, 1'b0, OP_ADD, 16'h0007, 1'b0, 1'b0);
    run_directed("add_wrap",    16'hFFFF, 16'h0001, 1'b0, OP_ADD, 16'h0000, 1'b1, 1'b0);
    run_directed("add_cin",     16'hFFFF, 16'h0000, 1'b1, OP_ADD, 16'h0000, 1'b1, 1'b0);
    run_directed("add_ovf",     16'h7FFF, 16'h0001, 1'b0, OP_ADD, 16'h8000, 1'b0, 1'b1);
    run_directed("sub_ovf",     16'h8000, 16'h0001, 1'b0, OP_SUB, 16'h7FFF, 1'b1, 1'b1);
    run_directed("sub_borrow",  16'h0005, 16'h0007, 1'b1, OP_SUB, 16'hFFFE, 1'b0, 1'b0);

    // Burst of 8 with a 3-cycle consumer stall in the middle.
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      end
      begin
        repeat (6) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("stall_in_ready", bus.in_ready, 1'b0);
          chk("stall_out_valid", bus.out_valid, 1'b1);
          @(posedge clk);
        end
        #1 bus.out_ready = 1'b1;
      end
    join
    t = 0;
    while (exp_q.size() != 0 && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    chk("burst_count", n_out - n0, 8);

    // Reset with beats in flight.
    send(16'h1234, 16'h1111, 1'b0, OP_ADD);
    send(16'h0F0F, 16'h0101, 1'b0, OP_ADD);
    send(16'hA000, 16'h0001, 1'b0, OP_SUB);
    send(16'h4444, 16'h2222, 1'b1, OP_ADD);
    chk("pre_reset_valid", bus.out_valid, 1'b1);
    chk("pre_reset_sum", bus.out_sum, 16'h2345);
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", bus.out_valid, 1'b0);
    chk("async_reset_sum", bus.out_sum, 16'h0000);
    chk("async_reset_flags", {bus.out_cout, bus.out_ovf}, 2'b00);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no_stale_valid", bus.out_valid, 1'b0);
    end
    @(posedge clk); #1;
    run_directed("post_reset", 16'h00AA, 16'h0055, 1'b0, OP_ADD, 16'h00FF, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
